poker_player_bot_v2: RTL
========================

# poker_player_bot_v2

Parametrised second-generation poker player. It replaces the hard-coded four-round, 8-bit player FSM with a single round-counted decision engine. Bets are sized from pot and stack. It has a per-round raise cap, an invalid-move retry limit with a safe fallback, and optional LFSR bluffing. It sits between the dealer FSM and a hand-strength evaluator and carries its own output_valid/dealer_acknowledge handshake.

## Interface
- MONEY_W, 8: width of all money quantities
- NUM_ROUNDS, 4: betting rounds per hand (preflop, flop, turn, river)
- MAX_RAISES, 3: own RAISE actions allowed per round; beyond this a raise degrades to CALL
- RETRY_LIMIT, 2: consecutive invalid_move responses before the fallback action
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- dealer_request_action  in  1  dealer asks for an action (level, sampled in wait states)
- dealer_acknowledge  in  1  dealer has taken action/make_bet
- output_valid  out  1  action/make_bet are valid; held until acknowledged
- action  out  3  action code
- make_bet  out  MONEY_W  bet/raise amount
- invalid_move  in  1  dealer rejected the last action
- strength  in  3  hand strength for the current round, 0 weakest, 7 strongest
- money_left  in  MONEY_W  own stack
- action_opponent  in  3  opponent's last action
- bet_opponent  in  MONEY_W  opponent's last bet
- pot_size  in  MONEY_W  current pot
- next_deal  in  1  hand over, new hand starting
- betting_round_done  in  1  current betting round closed
- round_idx  out  $clog2(NUM_ROUNDS)  current round, for debug/display

## Operation
- Action codes: NO_ACTION 000, FOLD 001, CHECK 010, ALL_IN 011, CALL 100, BET 110, RAISE 111.
- FSM states are IDLE, DECIDE, SEND, AWAIT.
  - IDLE: on dealer_request_action, go to DECIDE.
  - DECIDE: register action/make_bet, go to SEND.
  - SEND: output_valid=1. On dealer_acknowledge, go to AWAIT.
  - AWAIT, evaluated in priority order:
    - invalid_move: retry_cnt++, go to DECIDE.
    - dealer_request_action: go to DECIDE, clear retry_cnt.
    - betting_round_done: clear raise_cnt/retry_cnt, round_idx++, go to IDLE. If round_idx was NUM_ROUNDS-1, round_idx returns to 0.
- next_deal in any state forces IDLE and clears round_idx, raise_cnt, retry_cnt and output_valid. It has highest priority.
- Policy when opponent is NO_ACTION/CHECK/CALL:
  - strength ≥5: BET pot>>1.
  - strength 3–4: BET pot>>2.
  - otherwise: CHECK.
- Policy when opponent is FOLD: CHECK.
- Policy when opponent is BET/RAISE:
  - strength 7: RAISE 2×bet_opponent.
  - strength 5–6: CALL.
  - strength 3–4: CALL if bet_opponent ≤ pot>>2, else FOLD.
  - strength <3: FOLD.
- Policy when opponent is ALL_IN: CALL if strength ≥6, else FOLD.
- Arithmetic rules:
  - Amounts are computed at MONEY_W+1 bits.
  - A computed BET of 0 becomes 1.
  - Any BET/RAISE with amount ≥ money_left becomes ALL_IN with make_bet=money_left.
  - If raise_cnt==MAX_RAISES, RAISE becomes CALL.
  - raise_cnt increments only when a RAISE is acknowledged.
- Retry fallback: when retry_cnt==RETRY_LIMIT, DECIDE outputs CHECK if opponent is NO_ACTION/CHECK, else FOLD. make_bet is 0 for CHECK/CALL/FOLD.
- money_left==0: output CHECK if opponent is NO_ACTION/CHECK, else CALL.

## Timing
- Reset values:
  - output_valid 0, action 000, make_bet 0, round_idx 0, state IDLE.
  - Internal counters 0; LFSR seed 6'h01.
- Latency: request sampled at cycle t → DECIDE at t+1 → output_valid=1 at t+2.
- action/make_bet are stable while output_valid=1. output_valid drops the cycle after dealer_acknowledge is sampled.
- dealer_acknowledge outside SEND is ignored. invalid_move outside AWAIT is ignored.
- Inputs (strength, pot_size, opponent fields, money_left) are sampled only in DECIDE.
- Reset asserted mid-handshake: outputs drop asynchronously and the FSM restarts in IDLE.

## Configuration
- POKER_BOT_BLUFF_EN defined:
  - A 6-bit LFSR advances every clock.
  - In DECIDE, strength <3 with opponent NO_ACTION/CHECK bets pot>>2 when lfsr < 6'd16 (25%).
  - Facing BET/RAISE at strength 3–4 with bet_opponent > pot>>2, it calls when lfsr[5]=1.
- POKER_BOT_BLUFF_EN undefined: the LFSR is absent and the policy is fully deterministic as above.

## Structure
- Shared package poker_pkg holds:
  - Action code localparams.
  - The strength thresholds STR_VALUE=3, STR_STRONG=5, STR_PREMIUM=6, STR_NUTS=7.
  - The FSM state encoding.
- One sub-module, poker_bot_lfsr (6-bit, taps 6,5). It is instantiated only under POKER_BOT_BLUFF_EN.
- The decision policy is a combinational block inside the top module, registered in DECIDE.

## Test plan
- Open bet: reset, then request with strength=6, opponent=NO_ACTION, pot=40, money=100 → output_valid at t+2, action=BET, make_bet=20. Acknowledge → output_valid drops next cycle.
- Stack clamp: strength=7, opponent=RAISE, bet_opponent=60, money=100 → action=ALL_IN, make_bet=100.
- Raise cap: MAX_RAISES=3, strength=7, opponent=BET 4, four requests in one round → RAISE 8 three times, then CALL.
- Retry fallback: opponent=BET, strength=7, invalid_move twice → third output is FOLD with make_bet=0.
- Round and hand flow: betting_round_done four times → round_idx goes 1,2,3,0. next_deal asserted during SEND → output_valid=0 the next cycle, round_idx=0, state IDLE.
- Bluff (only with POKER_BOT_BLUFF_EN): strength=0, opponent=CHECK, pot=40, LFSR forced below 16 → action=BET, make_bet=10. Without the macro → CHECK.

Source files
------------

// File: rtl/poker_pkg.sv
// Shared definitions for the poker player bot: action codes, strength thresholds
// and the FSM state encoding.
package poker_pkg;

  localparam logic [2:0] ACT_NONE  = 3'b000;
  localparam logic [2:0] ACT_FOLD  = 3'b001;
  localparam logic [2:0] ACT_CHECK = 3'b010;
  localparam logic [2:0] ACT_ALLIN = 3'b011;
  localparam logic [2:0] ACT_CALL  = 3'b100;
  localparam logic [2:0] ACT_BET   = 3'b110;
  localparam logic [2:0] ACT_RAISE = 3'b111;

  localparam logic [2:0] STR_VALUE   = 3'd3;
  localparam logic [2:0] STR_STRONG  = 3'd5;
  localparam logic [2:0] STR_PREMIUM = 3'd6;
  localparam logic [2:0] STR_NUTS    = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_SEND   = 2'd2,
    ST_AWAIT  = 2'd3
  } state_e;

  // Opponent left the pot untouched, so checking costs nothing.
  function automatic logic opp_passive(input logic [2:0] opp);
    return (opp == ACT_NONE) || (opp == ACT_CHECK);
  endfunction

endpackage

// File: rtl/poker_bot_lfsr.sv
// 6-bit maximal-length Fibonacci LFSR (x^6 + x^5 + 1), free running from seed 6'h01.
module poker_bot_lfsr (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] lfsr_o
);

  logic [5:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 6'h01;
    else      lfsr_q <= {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/poker_player_bot_v2.sv
// Round-counted poker decision engine with dealer handshake, raise cap and retry fallback.
// Define POKER_BOT_BLUFF_EN to add LFSR-driven bluff bets and calls.
module poker_player_bot_v2
  import poker_pkg::*;
#(
  parameter int MONEY_W     = 8,
  parameter int NUM_ROUNDS  = 4,
  parameter int MAX_RAISES  = 3,
  parameter int RETRY_LIMIT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dealer_request_action,
  input  logic                          dealer_acknowledge,
  output logic                          output_valid,
  output logic [2:0]                    action,
  output logic [MONEY_W-1:0]            make_bet,
  input  logic                          invalid_move,
  input  logic [2:0]                    strength,
  input  logic [MONEY_W-1:0]            money_left,
  input  logic [2:0]                    action_opponent,
  input  logic [MONEY_W-1:0]            bet_opponent,
  input  logic [MONEY_W-1:0]            pot_size,
  input  logic                          next_deal,
  input  logic                          betting_round_done,
  output logic [$clog2(NUM_ROUNDS)-1:0] round_idx
);

  localparam int AW  = MONEY_W + 1;
  localparam int RW  = $clog2(NUM_ROUNDS);
  localparam int RCW = $clog2(MAX_RAISES + 1);
  localparam int TCW = $clog2(RETRY_LIMIT + 1);

  state_e             state_q, state_d;
  logic [2:0]         action_q, action_d;
  logic [MONEY_W-1:0] bet_q, bet_d;
  logic [RW-1:0]      round_q, round_d;
  logic [RCW-1:0]     raise_q, raise_d;
  logic [TCW-1:0]     retry_q, retry_d;

  logic               bluff_bet, bluff_call;

`ifdef POKER_BOT_BLUFF_EN
  logic [5:0] lfsr;

  poker_bot_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .lfsr_o (lfsr)
  );

  assign bluff_bet  = (lfsr < 6'd16);
  assign bluff_call = lfsr[5];
`else
  assign bluff_bet  = 1'b0;
  assign bluff_call = 1'b0;
`endif

  // Decision policy; one extra bit of headroom so 2x raises cannot wrap.
  logic [AW-1:0] pot_half, pot_qtr, raise_amt, amt;
  logic [2:0]    pol_act;
  logic          passive;

  assign pot_half  = {1'b0, pot_size} >> 1;
  assign pot_qtr   = {1'b0, pot_size} >> 2;
  assign raise_amt = {bet_opponent, 1'b0};
  assign passive   = opp_passive(action_opponent);

  always_comb begin
    pol_act = ACT_CHECK;
    amt     = '0;
    case (action_opponent)
      ACT_NONE, ACT_CHECK, ACT_CALL: begin
        if (strength >= STR_STRONG) begin
          pol_act = ACT_BET;
          amt     = pot_half;
        end else if (strength >= STR_VALUE || (passive && bluff_bet)) begin
          pol_act = ACT_BET;
          amt     = pot_qtr;
        end
      end
      ACT_BET, ACT_RAISE: begin
        if (strength == STR_NUTS) begin
          pol_act = ACT_RAISE;
          amt     = raise_amt;
        end else if (strength >= STR_STRONG) begin
          pol_act = ACT_CALL;
        end else if (strength >= STR_VALUE) begin
          pol_act = ({1'b0, bet_opponent} <= pot_qtr || bluff_call) ? ACT_CALL : ACT_FOLD;
        end else begin
          pol_act = ACT_FOLD;
        end
      end
      ACT_ALLIN: pol_act = (strength >= STR_PREMIUM) ? ACT_CALL : ACT_FOLD;
      default:   pol_act = ACT_CHECK;
    endcase

    if (pol_act == ACT_RAISE && raise_q == RCW'(MAX_RAISES)) pol_act = ACT_CALL;
    if (pol_act == ACT_BET && amt == '0) amt = AW'(1);
    if ((pol_act == ACT_BET || pol_act == ACT_RAISE) && amt >= {1'b0, money_left}) begin
      pol_act = ACT_ALLIN;
      amt     = {1'b0, money_left};
    end
    if (pol_act != ACT_BET && pol_act != ACT_RAISE && pol_act != ACT_ALLIN) amt = '0;

    // Broke players can only check or call; repeated rejections take the safest legal move.
    if (money_left == '0) begin
      pol_act = passive ? ACT_CHECK : ACT_CALL;
      amt     = '0;
    end
    if (retry_q == TCW'(RETRY_LIMIT)) begin
      pol_act = passive ? ACT_CHECK : ACT_FOLD;
      amt     = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    action_d = action_q;
    bet_d    = bet_q;
    round_d  = round_q;
    raise_d  = raise_q;
    retry_d  = retry_q;
    if (next_deal) begin
      state_d = ST_IDLE;
      round_d = '0;
      raise_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (dealer_request_action) state_d = ST_DECIDE;
        ST_DECIDE: begin
          action_d = pol_act;
          bet_d    = amt[MONEY_W-1:0];
          state_d  = ST_SEND;
        end
        ST_SEND: if (dealer_acknowledge) begin
          state_d = ST_AWAIT;
          if (action_q == ACT_RAISE) raise_d = raise_q + 1'b1;
        end
        ST_AWAIT: begin
          if (invalid_move) begin
            if (retry_q != TCW'(RETRY_LIMIT)) retry_d = retry_q + 1'b1;
            state_d = ST_DECIDE;
          end else if (dealer_request_action) begin
            retry_d = '0;
            state_d = ST_DECIDE;
          end else if (betting_round_done) begin
            raise_d = '0;
            retry_d = '0;
            round_d = (round_q == RW'(NUM_ROUNDS - 1)) ? '0 : round_q + 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      action_q <= ACT_NONE;
      bet_q    <= '0;
      round_q  <= '0;
      raise_q  <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      action_q <= action_d;
      bet_q    <= bet_d;
      round_q  <= round_d;
      raise_q  <= raise_d;
      retry_q  <= retry_d;
    end
  end

  assign output_valid = (state_q == ST_SEND);
  assign action       = action_q;
  assign make_bet     = bet_q;
  assign round_idx    = round_q;

endmodule
